// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions used by the training and inference sides.
package hdc_pkg;

    localparam int HDC_D = 10000;
    localparam int HDC_W = 100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    // One bundling step: +1 for a set bit, -1 for a clear bit, clamped symmetrically
    // so the most-negative two's-complement code never appears.
    function automatic int sat_step(input int cnt, input logic b, input int cnt_w);
        int lim;
        lim = (1 << (cnt_w - 1)) - 1;
        if (b) begin
            return (cnt >= lim) ? lim : cnt + 1;
        end
        return (cnt <= -lim) ? -lim : cnt - 1;
    endfunction

    // Majority vote; a tie (zero) resolves to 0.
    function automatic logic binarize(input int cnt);
        return cnt > 0;
    endfunction

endpackage

// File: rtl/hv_bundle_row.sv
// One row of W saturating bundle counters: next row from the current row and a sample chunk.
module hv_bundle_row
    import hdc_pkg::*;
#(
    parameter int W     = HDC_W,
    parameter int CNT_W = 8
) (
    input  logic [W*CNT_W-1:0] row_in,
    input  logic [W-1:0]       data,
    input  logic               zero,
    output logic [W*CNT_W-1:0] row_out
);

    // Per-lane saturating update; zero overrides everything so the same path clears rows.
    always_comb begin
        row_out = '0;
        if (!zero) begin
            for (int i = 0; i < W; i++) begin
                row_out[i*CNT_W +: CNT_W] =
                    CNT_W'(sat_step(int'(signed'(row_in[i*CNT_W +: CNT_W])), data[i], CNT_W));
            end
        end
    end

endmodule

// File: rtl/hv_class_trainer.sv
// Class-hypervector trainer: bundles labelled binary samples into per-class counters
// and streams the majority-binarized class vectors out on command.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no sample in progress; accepts chunk 0 or a command
// ST_TRAIN | mid-sample; accepts chunks 1..CHUNKS-1, commands ignored
// ST_CLEAR | zeroing one chunk row of every class per cycle
// ST_DUMP  | streaming binarized class rows, class-major
module hv_class_trainer
    import hdc_pkg::*;
#(
    parameter int D           = HDC_D,
    parameter int W           = HDC_W,
    parameter int NUM_CLASSES = 2,
    parameter int CNT_W       = 8,
    localparam int CHUNKS     = D / W,
    localparam int IDX_W      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_clear,
    input  logic             cmd_dump,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic [CLS_W-1:0] s_label,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic [CLS_W-1:0] m_class,
    output logic             m_last,
    output logic             busy,
    output logic             err
);

    localparam int RW = W * CNT_W;

    if (D % W != 0) begin : g_bad_dim
        $error("hv_class_trainer: D must be a multiple of W");
    end

    logic [RW-1:0]    mem [NUM_CLASSES][CHUNKS];
    logic [RW-1:0]    row_cur [NUM_CLASSES];
    logic [RW-1:0]    row_nxt [NUM_CLASSES];
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CLS_W-1:0] cls;
    logic             discard;
    logic             clearing;
    logic             accept;
    logic             last_idx;
    logic             last_cls;
    logic             lbl_ok;
    logic [CLS_W-1:0] wr_cls;
    logic [CLS_W-1:0] rd_cls;
    logic [IDX_W-1:0] rd_idx;
    logic [RW-1:0]    rd_row;
    logic [W-1:0]     rd_bits;

    assign clearing = (state == ST_CLEAR);
    assign s_ready  = (state == ST_IDLE) || (state == ST_TRAIN);
    assign busy     = (state == ST_CLEAR) || (state == ST_DUMP);
    assign accept   = s_valid && s_ready;
    assign last_idx = (idx == IDX_W'(CHUNKS - 1));
    assign last_cls = (cls == CLS_W'(NUM_CLASSES - 1));
    // The label is only trusted on chunk 0; later chunks reuse the latched class.
    assign wr_cls   = (state == ST_IDLE) ? s_label : cls;
    assign lbl_ok   = (state == ST_IDLE) ? (int'(s_label) < NUM_CLASSES) : !discard;

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
        assign row_cur[c] = mem[c][idx];
        hv_bundle_row #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_row (
            .row_in  (row_cur[c]),
            .data    (s_data),
            .zero    (clearing),
            .row_out (row_nxt[c])
        );
    end

    // Address of the row the dump stream presents next, and its binarized contents.
    always_comb begin
        rd_cls = '0;
        rd_idx = '0;
        if (state == ST_DUMP) begin
            if (last_idx) begin
                rd_idx = '0;
                rd_cls = last_cls ? '0 : cls + CLS_W'(1);
            end else begin
                rd_idx = idx + IDX_W'(1);
                rd_cls = cls;
            end
        end
        rd_row = mem[rd_cls][rd_idx];
        for (int i = 0; i < W; i++) begin
            rd_bits[i] = binarize(int'(signed'(rd_row[i*CNT_W +: CNT_W])));
        end
    end

    // Counter storage: training writes one row of the sample's class, clearing writes all classes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                for (int k = 0; k < CHUNKS; k++) begin
                    mem[c][k] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (clearing || (accept && lbl_ok && (wr_cls == CLS_W'(c)))) begin
                    mem[c][idx] <= row_nxt[c];
                end
            end
        end
    end

    // Sequencing FSM with registered stream outputs and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            cls     <= '0;
            discard <= 1'b0;
            err     <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_class <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_TRAIN: begin
                    if (accept) begin
                        if (state == ST_IDLE) begin
                            cls     <= s_label;
                            discard <= !lbl_ok;
                            if (!lbl_ok) begin
                                err <= 1'b1;
                            end
                        end
                        if (s_last != last_idx) begin
                            err <= 1'b1;
                        end
                        if (s_last || last_idx) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end else begin
                            state <= ST_TRAIN;
                            idx   <= idx + IDX_W'(1);
                        end
                    end else if (state == ST_IDLE && cmd_clear) begin
                        state <= ST_CLEAR;
                        idx   <= '0;
                        err   <= 1'b0;
                    end else if (state == ST_IDLE && cmd_dump) begin
                        // rd_* point at row {0,0} while idle, so the first chunk is ready at once.
                        state   <= ST_DUMP;
                        idx     <= '0;
                        cls     <= '0;
                        m_valid <= 1'b1;
                        m_data  <= rd_bits;
                        m_class <= '0;
                        m_last  <= 1'(CHUNKS == 1);
                    end
                end
                ST_CLEAR: begin
                    if (last_idx) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DUMP: begin
                    if (m_ready) begin
                        if (last_idx && last_cls) begin
                            state   <= ST_IDLE;
                            idx     <= '0;
                            cls     <= '0;
                            m_valid <= 1'b0;
                            m_data  <= '0;
                            m_class <= '0;
                            m_last  <= 1'b0;
                        end else begin
                            idx     <= rd_idx;
                            cls     <= rd_cls;
                            m_data  <= rd_bits;
                            m_class <= rd_cls;
                            m_last  <= (rd_idx == IDX_W'(CHUNKS - 1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_class_trainer.sv
// Randomized bench for hv_class_trainer with a scoreboard fed by an integer counter model.
module tb_hv_class_trainer;

    localparam int D  = 16;
    localparam int W  = 8;
    localparam int NC = 2;
    localparam int CW = 4;
    localparam int CH = D / W;
    localparam int LIM = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_clear = 1'b0;
    logic         cmd_dump = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         s_label = 1'b0;
    logic         s_last = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_class;
    logic         m_last;
    logic         busy;
    logic         err;

    typedef struct {
        logic [W-1:0] data;
        logic         cls;
        logic         last;
    } exp_t;

    exp_t q[$];
    int   cnt [NC][D];
    int   errors = 0;
    int   checks = 0;

    hv_class_trainer #(
        .D           (D),
        .W           (W),
        .NUM_CLASSES (NC),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_clear (cmd_clear),
        .cmd_dump  (cmd_dump),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_label   (s_label),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_class   (m_class),
        .m_last    (m_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < D; b++)
                cnt[c][b] = 0;
    endtask

    task automatic model_add(input int c, input int k, input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            if (d[i]) cnt[c][k*W+i] = (cnt[c][k*W+i] + 1 > LIM) ? LIM : cnt[c][k*W+i] + 1;
            else      cnt[c][k*W+i] = (cnt[c][k*W+i] - 1 < -LIM) ? -LIM : cnt[c][k*W+i] - 1;
        end
    endtask

    function automatic logic [W-1:0] exp_chunk(input int c, input int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = (cnt[c][k*W+i] > 0);
        return r;
    endfunction

    task automatic send_chunk(input logic lbl, input logic [W-1:0] d, input logic last);
        s_valid = 1'b1;
        s_label = lbl;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_sample(input logic lbl, input logic [W-1:0] d0, input logic [W-1:0] d1);
        send_chunk(lbl, d0, 1'b0);
        model_add(int'(lbl), 0, d0);
        send_chunk(lbl, d1, 1'b1);
        model_add(int'(lbl), 1, d1);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_dump(input int mode);
        exp_t e;
        int   n;
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < CH; k++) begin
                e.data = exp_chunk(c, k);
                e.cls  = (c == 1);
                e.last = (k == CH - 1);
                q.push_back(e);
            end
        end
        cmd_dump = 1'b1;
        tick();
        cmd_dump = 1'b0;
        chk("m_valid_after_cmd_dump", 32'(m_valid), 32'd1);
        n = 0;
        while (q.size() != 0 && n < 64) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((n % 4) == 0) || ((n % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            n++;
        end
        m_ready = 1'b0;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout: %0d chunks still outstanding after 64 cycles", q.size());
            q.delete();
        end else begin
            chk("busy_after_last_handshake", 32'(busy), 32'd0);
            chk("s_ready_after_last_handshake", 32'(s_ready), 32'd1);
            chk("m_valid_after_last_handshake", 32'(m_valid), 32'd0);
        end
    endtask

    // Scoreboard monitor: compares every presented chunk, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && m_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_chunk: got data=%0h class=%0d with nothing expected",
                             m_data, m_class);
                end else begin
                    chk("dump_chunk {data,class,last}", {22'd0, m_data, m_class, m_last},
                        {22'd0, q[0].data, q[0].cls, q[0].last});
                    if (m_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
        model_zero();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // reset values
        chk("reset_s_ready", 32'(s_ready), 32'd1);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_m_class", 32'(m_class), 32'd0);
        chk("reset_m_last", 32'(m_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // three class-0 samples; class 1 stays at tie
        send_sample(1'b0, 8'hFF, 8'h00);
        send_sample(1'b0, 8'hFF, 8'h0F);
        send_sample(1'b0, 8'h0F, 8'h00);
        chk("err_after_clean_samples", 32'(err), 32'd0);
        run_dump(0);

        // saturation at +7, then one all-zero sample leaves +6
        for (int s = 0; s < 10; s++) send_sample(1'b1, 8'hFF, 8'hFF);
        send_sample(1'b1, 8'h00, 8'h00);
        run_dump(1);

        // early s_last on chunk 0, next chunk starts a fresh sample
        a = 8'($urandom);
        send_chunk(1'b0, a, 1'b1);
        model_add(0, 0, a);
        chk("err_early_last", 32'(err), 32'd1);
        send_sample(1'b1, 8'($urandom), 8'($urandom));
        run_dump(2);

        // clear: err drops, busy for exactly CH cycles
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        model_zero();
        chk("err_after_clear", 32'(err), 32'd0);
        chk("clear_busy_cycle1", 32'(busy), 32'd1);
        chk("clear_s_ready_cycle1", 32'(s_ready), 32'd0);
        tick();
        chk("clear_busy_cycle2", 32'(busy), 32'd1);
        tick();
        chk("clear_busy_done", 32'(busy), 32'd0);
        chk("clear_s_ready_done", 32'(s_ready), 32'd1);

        // random training, occasional idle gaps
        for (int s = 0; s < 16; s++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send_sample(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        run_dump(2);

        // cmd_dump mid-sample is ignored
        a = 8'($urandom);
        b = 8'($urandom);
        send_chunk(1'b1, a, 1'b0);
        model_add(1, 0, a);
        cmd_dump = 1'b1;
        tick();
        cmd_dump = 1'b0;
        chk("midsample_dump_m_valid", 32'(m_valid), 32'd0);
        chk("midsample_dump_busy", 32'(busy), 32'd0);
        send_chunk(1'b1, b, 1'b1);
        model_add(1, 1, b);
        tick();
        chk("midsample_dump_m_valid_later", 32'(m_valid), 32'd0);
        run_dump(0);

        // clear and dump together: clear only
        cmd_clear = 1'b1;
        cmd_dump  = 1'b1;
        tick();
        cmd_clear = 1'b0;
        cmd_dump  = 1'b0;
        model_zero();
        chk("clr_dump_busy1", 32'(busy), 32'd1);
        chk("clr_dump_m_valid1", 32'(m_valid), 32'd0);
        tick();
        chk("clr_dump_busy2", 32'(busy), 32'd1);
        tick();
        chk("clr_dump_busy3", 32'(busy), 32'd0);
        chk("clr_dump_m_valid3", 32'(m_valid), 32'd0);
        run_dump(0);

        // reset during dump after one handshake
        send_sample(1'b0, 8'hFF, 8'hFF);
        send_sample(1'b1, 8'($urandom), 8'($urandom));
        e.data = exp_chunk(0, 0);
        e.cls  = 1'b0;
        e.last = 1'b0;
        q.push_back(e);
        cmd_dump = 1'b1;
        tick();
        cmd_dump = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dump_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_dump_m_data", 32'(m_data), 32'd0);
        chk("rst_mid_dump_busy", 32'(busy), 32'd0);
        chk("rst_mid_dump_first_chunk_seen", 32'(q.size()), 32'd0);
        q.delete();
        tick();
        rst_n = 1'b1;
        model_zero();
        tick();
        run_dump(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
